// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder.
// FEEDER_SKEW_EN (when defined) selects the diagonally skewed edge build.
package systolic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_STREAM,
      ST_FLUSH,
      ST_DONE
   } state_e;

   // PE input register plus accumulator register.
   localparam int PIPE_LAT = 2;

   // The skewed build must also drain the longest skew line (N-1 stages).
   function automatic int flush_len(input int n, input bit skew);
      return PIPE_LAT + (skew ? (n - 1) : 0);
   endfunction

   function automatic int lane_lo(input int lane, input int w);
      return lane * w;
   endfunction

endpackage

// File: rtl/feeder_skew_line.sv
// Fixed-depth delay line for one edge lane; DEPTH=0 degenerates to a wire.
module feeder_skew_line #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst;
         assign unused_clk_rst = i_clk ^ i_rst;
         assign q_o = d_i;
      end else begin : g_dly
         logic [DEPTH-1:0][WIDTH-1:0] sr_q;
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               sr_q <= '0;
            end else begin
               sr_q[0] <= d_i;
               for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
            end
         end
         assign q_o = sr_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Feeds A/B operand beats onto the PE array edges, bracketing each tile with
// sync, a zero flush and a done pulse. Define FEEDER_SKEW_EN for per-lane skew.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int W     = 16,
   parameter int N     = 4,
   parameter int K_MAX = 255
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [N*W-1:0]             s_a,
   input  logic [N*W-1:0]             s_b,
   input  logic                       s_last,
   input  logic                       i_mode,
   output logic [N*W-1:0]             o_A_edge,
   output logic [N*W-1:0]             o_B_edge,
   output logic                       o_en,
   output logic                       o_sync,
   output logic                       o_mode,
   output logic                       o_done,
   output logic [$clog2(K_MAX+1)-1:0] o_beats,
   output logic                       o_ovf
);

   localparam int CW = $clog2(K_MAX + 1);
`ifdef FEEDER_SKEW_EN
   localparam bit SKEW = 1'b1;
`else
   localparam bit SKEW = 1'b0;
`endif
   localparam int FLUSH_LEN = flush_len(N, SKEW);
   localparam int FW        = $clog2(FLUSH_LEN + 1);

   state_e          state_q, state_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic [N*W-1:0]  a_q, a_d, b_q, b_d;
   logic [CW-1:0]   beats_q, beats_d;
   logic            ovf_q, ovf_d, mode_q, mode_d;
   logic            ready_q, en_q, sync_q, done_q;
   logic            accept;

   assign accept = s_valid & ready_q;

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      a_d     = '0;
      b_d     = '0;
      beats_d = beats_q;
      ovf_d   = ovf_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: if (s_valid) state_d = ST_SYNC;
         ST_SYNC: begin
            mode_d  = i_mode;
            beats_d = '0;
            ovf_d   = 1'b0;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            // Idle cycles push zeros: a zero product is a harmless bubble.
            if (accept) begin
               a_d = s_a;
               b_d = s_b;
               if (beats_q == CW'(K_MAX)) ovf_d = 1'b1;
               else beats_d = beats_q + CW'(1);
               if (s_last) begin
                  state_d = ST_FLUSH;
                  fcnt_d  = FW'(FLUSH_LEN - 1);
               end
            end
         end
         ST_FLUSH: begin
            if (fcnt_q == '0) state_d = ST_DONE;
            else fcnt_d = fcnt_q - FW'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         fcnt_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         beats_q <= '0;
         ovf_q   <= 1'b0;
         mode_q  <= 1'b0;
         ready_q <= 1'b0;
         en_q    <= 1'b0;
         sync_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         beats_q <= beats_d;
         ovf_q   <= ovf_d;
         mode_q  <= mode_d;
         // Strobes decoded from next state so they leave a flop directly.
         ready_q <= (state_d == ST_STREAM);
         en_q    <= (state_d == ST_SYNC) || (state_d == ST_STREAM) || (state_d == ST_FLUSH);
         sync_q  <= (state_d == ST_SYNC);
         done_q  <= (state_d == ST_DONE);
      end
   end

`ifdef FEEDER_SKEW_EN
   for (genvar i = 0; i < N; i++) begin : g_lane
      feeder_skew_line #(.WIDTH(W), .DEPTH(i)) u_skew_a (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .d_i   (a_q[lane_lo(i, W) +: W]),
         .q_o   (o_A_edge[lane_lo(i, W) +: W])
      );
      feeder_skew_line #(.WIDTH(W), .DEPTH(i)) u_skew_b (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .d_i   (b_q[lane_lo(i, W) +: W]),
         .q_o   (o_B_edge[lane_lo(i, W) +: W])
      );
   end
`else
   assign o_A_edge = a_q;
   assign o_B_edge = b_q;
`endif

   assign s_ready = ready_q;
   assign o_en    = en_q;
   assign o_sync  = sync_q;
   assign o_done  = done_q;
   assign o_mode  = mode_q;
   assign o_beats = beats_q;
   assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, W=16, K_MAX=3); honours FEEDER_SKEW_EN.
module tb_systolic_feeder;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int KM = 3;
`ifdef FEEDER_SKEW_EN
   localparam int          FL = 5;
   localparam logic [63:0] LM = 64'h0000_0000_0000_FFFF;  // only lane 0 is undelayed
`else
   localparam int          FL = 2;
   localparam logic [63:0] LM = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

   localparam logic [63:0] A0 = 64'h0004_0003_0002_0001;
   localparam logic [63:0] A1 = 64'h0014_0013_0012_0011;
   localparam logic [63:0] A2 = 64'h0024_0023_0022_0021;
   localparam logic [63:0] B0 = 64'h000D_000C_000B_000A;
   localparam logic [63:0] B1 = 64'h001D_001C_001B_001A;
   localparam logic [63:0] B2 = 64'h002D_002C_002B_002A;

   logic        i_clk = 1'b0, i_rst = 1'b1;
   logic        s_valid = 1'b0, s_last = 1'b0, i_mode = 1'b0;
   logic [63:0] s_a = '0, s_b = '0;
   logic        s_ready, o_en, o_sync, o_mode, o_done, o_ovf;
   logic [63:0] o_A_edge, o_B_edge;
   logic [1:0]  o_beats;
   logic [3:0]  ctl;
   int          tests = 0, fails = 0;

   assign ctl = {s_ready, o_en, o_sync, o_done};

   systolic_feeder #(.W(W), .N(N), .K_MAX(KM)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_a(s_a), .s_b(s_b), .s_last(s_last), .i_mode(i_mode),
      .o_A_edge(o_A_edge), .o_B_edge(o_B_edge), .o_en(o_en), .o_sync(o_sync),
      .o_mode(o_mode), .o_done(o_done), .o_beats(o_beats), .o_ovf(o_ovf)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick(); tick();
      tests++; if (ctl !== 4'b0000) begin fails++; $display("FAIL reset_ctl got %b exp 0000", ctl); end
      tests++; if ({o_A_edge, o_B_edge} !== 128'd0) begin fails++; $display("FAIL reset_edges got %h %h exp 0", o_A_edge, o_B_edge); end
      tests++; if ({o_mode, o_ovf, o_beats} !== 4'd0) begin fails++; $display("FAIL reset_status got %b%b%0d exp 0", o_mode, o_ovf, o_beats); end
      i_rst = 1'b0;
      tick();
      tests++; if (ctl !== 4'b0000) begin fails++; $display("FAIL idle_ctl got %b exp 0000", ctl); end
   endtask

   task automatic test_three_beat();
      s_valid = 1'b1; s_a = A0; s_b = B0; s_last = 1'b0;
      tick();
      tests++; if (ctl !== 4'b0110) begin fails++; $display("FAIL tb3_sync got %b exp 0110", ctl); end
      tick();
      tests++; if (ctl !== 4'b1100) begin fails++; $display("FAIL tb3_stream got %b exp 1100", ctl); end
      tests++; if ({o_A_edge, o_beats} !== {64'd0, 2'd0}) begin fails++; $display("FAIL tb3_sync_no_consume edge %h beats %0d", o_A_edge, o_beats); end
      tick();
      tests++; if ((o_A_edge & LM) !== (A0 & LM) || (o_B_edge & LM) !== (B0 & LM)) begin fails++; $display("FAIL tb3_beat0 got %h %h", o_A_edge, o_B_edge); end
      s_a = A1; s_b = B1;
      tick();
      tests++; if ((o_A_edge & LM) !== (A1 & LM) || (o_B_edge & LM) !== (B1 & LM)) begin fails++; $display("FAIL tb3_beat1 got %h %h", o_A_edge, o_B_edge); end
      s_a = A2; s_b = B2; s_last = 1'b1;
      tick();
      tests++; if ((o_A_edge & LM) !== (A2 & LM) || (o_B_edge & LM) !== (B2 & LM)) begin fails++; $display("FAIL tb3_beat2 got %h %h", o_A_edge, o_B_edge); end
      tests++; if (o_beats !== 2'd3) begin fails++; $display("FAIL tb3_beats got %0d exp 3", o_beats); end
      tests++; if (ctl !== 4'b0100) begin fails++; $display("FAIL tb3_flush0 got %b exp 0100", ctl); end
      s_valid = 1'b0; s_last = 1'b0;
      for (int k = 1; k < FL; k++) begin
         tick();
         tests++; if (ctl !== 4'b0100) begin fails++; $display("FAIL tb3_flush%0d got %b exp 0100", k, ctl); end
      end
      tick();
      tests++; if (ctl !== 4'b0001) begin fails++; $display("FAIL tb3_done got %b exp 0001", ctl); end
      tests++; if ({o_A_edge, o_B_edge} !== 128'd0) begin fails++; $display("FAIL tb3_done_edges got %h %h", o_A_edge, o_B_edge); end
      tick();
      tests++; if (ctl !== 4'b0000 || o_beats !== 2'd3) begin fails++; $display("FAIL tb3_idle ctl %b beats %0d exp 0000/3", ctl, o_beats); end
   endtask

   task automatic test_bubbles();
      s_valid = 1'b1; s_a = A0; s_b = B0; s_last = 1'b0;
      tick(); tick(); tick();
      tests++; if ((o_A_edge & LM) !== (A0 & LM)) begin fails++; $display("FAIL bub_beat0 got %h", o_A_edge); end
      s_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         tests++; if ((o_A_edge & LM) !== 64'd0 || (o_B_edge & LM) !== 64'd0 || ctl !== 4'b1100) begin
            fails++; $display("FAIL bub_zero%0d edges %h %h ctl %b", k, o_A_edge, o_B_edge, ctl);
         end
      end
      s_valid = 1'b1; s_a = A1; s_b = B1; s_last = 1'b1;
      tick();
      tests++; if ((o_B_edge & LM) !== (B1 & LM) || o_beats !== 2'd2) begin fails++; $display("FAIL bub_beat1 got %h beats %0d", o_B_edge, o_beats); end
      s_valid = 1'b0; s_last = 1'b0;
      for (int k = 1; k < FL; k++) tick();
      tests++; if (o_done !== 1'b0) begin fails++; $display("FAIL bub_early_done got %b exp 0", o_done); end
      tick();
      tests++; if (ctl !== 4'b0001) begin fails++; $display("FAIL bub_done got %b exp 0001", ctl); end
      tick();
   endtask

`ifdef FEEDER_SKEW_EN
   task automatic test_skew();
      logic [63:0] exp;
      s_valid = 1'b1; s_a = 64'h0007_0007_0007_0007; s_b = 64'h0007_0007_0007_0007; s_last = 1'b1;
      tick(); tick(); tick();
      s_valid = 1'b0; s_last = 1'b0;
      exp = 64'h7;
      for (int k = 0; k < 5; k++) begin
         tests++; if (o_A_edge !== exp || o_B_edge !== exp || ctl !== 4'b0100) begin
            fails++; $display("FAIL skew_c%0d got %h %h ctl %b exp %h 0100", k, o_A_edge, o_B_edge, ctl, exp);
         end
         exp = exp << 16;
         tick();
      end
      tests++; if (ctl !== 4'b0001) begin fails++; $display("FAIL skew_done got %b exp 0001", ctl); end
      tick();
   endtask
`endif

   task automatic test_overflow();
      logic [1:0] eb [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      logic       eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      s_valid = 1'b1; s_last = 1'b0;
      tick(); tick();
      for (int k = 0; k < 5; k++) begin
         s_a = 64'(k + 100); s_last = (k == 4);
         tick();
         tests++; if (o_beats !== eb[k] || o_ovf !== eo[k] || (o_A_edge & LM) !== (64'(k + 100) & LM)) begin
            fails++; $display("FAIL ovf_beat%0d beats %0d ovf %b edge %h exp %0d %b", k, o_beats, o_ovf, o_A_edge, eb[k], eo[k]);
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      for (int k = 0; k < FL; k++) tick();
      tests++; if (o_done !== 1'b1 || o_ovf !== 1'b1) begin fails++; $display("FAIL ovf_done done %b ovf %b exp 1 1", o_done, o_ovf); end
      tick();
   endtask

   task automatic test_mode();
      i_mode = 1'b1; s_valid = 1'b1; s_a = A0; s_b = B0; s_last = 1'b0;
      tick();
      tick();
      tests++; if ({o_mode, o_ovf, o_beats} !== 4'b1000) begin fails++; $display("FAIL mode_sync mode %b ovf %b beats %0d exp 1 0 0", o_mode, o_ovf, o_beats); end
      i_mode = 1'b0;
      tick();
      i_mode = 1'b1; s_last = 1'b1;
      tick();
      i_mode = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      for (int k = 0; k < FL; k++) begin
         tests++; if (o_mode !== 1'b1) begin fails++; $display("FAIL mode_hold%0d got %b exp 1", k, o_mode); end
         tick();
      end
      tests++; if (o_done !== 1'b1 || o_mode !== 1'b1) begin fails++; $display("FAIL mode_done done %b mode %b exp 1 1", o_done, o_mode); end
      tick();
      s_valid = 1'b1; s_last = 1'b1;
      tick();
      tests++; if (o_mode !== 1'b1) begin fails++; $display("FAIL mode_presync got %b exp 1", o_mode); end
      tick();
      tests++; if (o_mode !== 1'b0) begin fails++; $display("FAIL mode_update got %b exp 0", o_mode); end
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      for (int k = 0; k < FL + 1; k++) tick();
   endtask

   task automatic test_reset_mid();
      logic saw_done;
      i_mode = 1'b1; s_valid = 1'b1; s_a = A0; s_b = B0; s_last = 1'b0;
      tick(); tick(); tick();
      s_a = A1; s_b = B1;
      tick();
      tests++; if (o_beats !== 2'd2 || o_mode !== 1'b1) begin fails++; $display("FAIL rst_pre beats %0d mode %b exp 2 1", o_beats, o_mode); end
      i_rst = 1'b1; s_valid = 1'b0;
      tick();
      tests++; if ({ctl, o_mode, o_ovf, o_beats} !== 8'd0 || {o_A_edge, o_B_edge} !== 128'd0) begin
         fails++; $display("FAIL rst_mid ctl %b mode %b ovf %b beats %0d edges %h %h", ctl, o_mode, o_ovf, o_beats, o_A_edge, o_B_edge);
      end
      i_rst = 1'b0; i_mode = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < 8; k++) begin tick(); saw_done |= o_done; end
      tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL rst_no_done got %b exp 0", saw_done); end
      s_valid = 1'b1; s_a = A2; s_b = B2; s_last = 1'b1;
      tick();
      tests++; if (ctl !== 4'b0110) begin fails++; $display("FAIL rst_new_sync got %b exp 0110", ctl); end
      tick(); tick();
      s_valid = 1'b0; s_last = 1'b0;
      tests++; if ((o_A_edge & LM) !== (A2 & LM) || o_beats !== 2'd1) begin fails++; $display("FAIL rst_new_beat got %h beats %0d", o_A_edge, o_beats); end
      for (int k = 0; k < FL; k++) tick();
      tests++; if (ctl !== 4'b0001) begin fails++; $display("FAIL rst_new_done got %b exp 0001", ctl); end
      tick();
   endtask

   initial begin
      test_reset();
      test_three_beat();
      test_bubbles();
`ifdef FEEDER_SKEW_EN
      test_skew();
`endif
      test_overflow();
      test_mode();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Producer end of the PE array edge interface: drives the west-edge A lanes, north-edge B lanes, enable, mode and sync that the PE grid consumes.
- Accepts one A row-vector and one B column-vector per beat over a valid/ready stream and registers them onto the array edges.
- Brackets each tile with a sync pulse, then flushes zeros so every accumulator settles, then signals completion.
- Sits between the operand staging buffers and the PE grid.

Parameters:
- W, 16, element width in bits; matches PE operand width.
- N, 4, array dimension: number of A lanes and of B lanes.
- K_MAX, 255, maximum beats per tile; sets beat-counter width to clog2(K_MAX+1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- s_valid  in  1  beat offered.
- s_ready  out  1  beat accepted when s_valid & s_ready.
- s_a  in  N*W  A lanes; lane i = bits [i*W +: W].
- s_b  in  N*W  B lanes; same packing.
- s_last  in  1  final beat of the tile.
- i_mode  in  1  MAC mode for the tile; sampled in SYNC.
- o_A_edge  out  N*W  to the west-edge PE i_A inputs.
- o_B_edge  out  N*W  to the north-edge PE i_B inputs.
- o_en  out  1  array enable.
- o_sync  out  1  accumulator-clear pulse.
- o_mode  out  1  latched mode.
- o_done  out  1  one-cycle pulse; PE o_C values are final.
- o_beats  out  clog2(K_MAX+1)  beats accepted in the current or last tile.
- o_ovf  out  1  sticky: more than K_MAX beats were accepted.

Behaviour:
- Reset i_rst, synchronous, active-high.
- Reset values:
  - State IDLE.
  - All outputs 0, including s_ready, edges, o_mode, o_beats and o_ovf.
  - Skew lines cleared.
- Reset mid-tile aborts immediately: no o_done, edges zero on the next cycle.
- States:
  - IDLE: s_ready=0, o_en=0. On s_valid go to SYNC; the beat is not consumed.
  - SYNC (1 cycle): o_sync=1, o_en=1, s_ready=0. o_mode<=i_mode, o_beats<=0, o_ovf<=0. Go to STREAM.
  - STREAM: s_ready=1, o_en=1.
    - Accepted beat: edges <= s_a/s_b on the next edge (latency 1).
    - Cycle with s_valid=0: edges <= 0. This is a zero bubble; products add nothing, so no stall signalling is needed.
    - Accepted beat with s_last: go to FLUSH, counter=FLUSH_LEN-1.
  - FLUSH: s_ready=0, o_en=1, edges 0. Counter decrements; at 0 go to DONE.
    - FLUSH_LEN = 2 (PE input register plus accumulator register) + skew term (see Optional Feature).
  - DONE (1 cycle): o_done=1, o_en=0, edges 0. Go to IDLE.
- o_beats counts accepted beats and saturates at K_MAX. A beat accepted while o_beats==K_MAX sets o_ovf; the beat is still forwarded.
- A single-beat tile (s_last on the first beat) is legal.
- s_last in SYNC is ignored because no beat is consumed there.
- o_mode holds from SYNC until the next SYNC.
- Edge outputs are registered; o_en, o_sync and o_done are decoded from state and are glitch-free registered.

Optional Feature:
- Macro FEEDER_SKEW_EN.
- Defined:
  - Lane i of both A and B passes through an i-stage delay (lane 0 undelayed) for systolic diagonal skew.
  - FLUSH_LEN = 2 + (N-1).
  - Skew lines are flushed with zeros.
- Undefined:
  - All lanes are aligned (broadcast-forwarding array).
  - FLUSH_LEN = 2.
  - No skew registers are instantiated.

Decomposition:
- Package systolic_pkg holds:
  - the state encoding (IDLE, SYNC, STREAM, FLUSH, DONE);
  - the FLUSH_LEN computation;
  - the lane slice helper.
- One sub-module: feeder_skew_line (parameters WIDTH, DEPTH; DEPTH=0 is a wire). It is instantiated per lane under FEEDER_SKEW_EN.

Test Plan:
- Reset then 3-beat tile (no skew, N=4), s_valid held high, lane i of s_a = i+1 and of s_b = 10+i:
  - o_sync pulses 1 cycle after s_valid rises.
  - Edges show the beats on 3 consecutive cycles.
  - Flush lasts 2 cycles, then o_done for 1 cycle.
  - o_beats=3.
- Bubbles: 2 beats separated by 2 cycles of s_valid=0:
  - Edges are zero during the bubbles.
  - o_done arrives 2 cycles after the 2nd beat's flush starts.
  - o_beats=2.
- FEEDER_SKEW_EN, N=4, single beat with all lanes=7:
  - Lane i shows 7 exactly i cycles after lane 0.
  - Flush lasts 5 cycles.
  - o_done follows.
- Overflow, K_MAX=3, 5 beats:
  - o_beats saturates at 3, o_ovf=1 after beat 4.
  - o_ovf clears at the next tile's SYNC.
- Reset asserted in STREAM after 2 beats:
  - Next cycle: all outputs 0 and state IDLE.
  - No o_done.
  - A new tile then runs normally.
- i_mode=1 at SYNC then toggled mid-tile: o_mode stays 1 through DONE and updates only at the next SYNC.
